// File: rtl/rs_branch_gen.sv
// Branch reservation station: CDB wakeup, oldest-ready issue into a held issue register.
// Optional macro RS_BRANCH_WAKEUP_BYPASS_EN lets a same-cycle CDB match make an entry ready.
module rs_branch_gen #(
  parameter int DEPTH    = 4,
  parameter int SEL_W    = 2,
  parameter int NCDB     = 2,
  parameter int DATA_W   = 32,
  parameter int TAG_W    = 4,
  parameter int TAG_FREE = 0,
  parameter int ADDR_W   = 32,
  parameter int OP_W     = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     alloc_valid,
  output logic                     alloc_ready,
  input  logic [DATA_W-1:0]        alloc_data1,
  input  logic [DATA_W-1:0]        alloc_data2,
  input  logic [TAG_W-1:0]         alloc_tag1,
  input  logic [TAG_W-1:0]         alloc_tag2,
  input  logic [DATA_W-1:0]        alloc_offset,
  input  logic [ADDR_W-1:0]        alloc_pc,
  input  logic [OP_W-1:0]          alloc_op,
  input  logic [NCDB-1:0]          cdb_valid,
  input  logic [NCDB*TAG_W-1:0]    cdb_tag,
  input  logic [NCDB*DATA_W-1:0]   cdb_data,
  output logic                     issue_valid,
  input  logic                     issue_ready,
  output logic [DATA_W-1:0]        issue_src1,
  output logic [DATA_W-1:0]        issue_src2,
  output logic [DATA_W-1:0]        issue_offset,
  output logic [ADDR_W-1:0]        issue_pc,
  output logic [OP_W-1:0]          issue_op,
  output logic [SEL_W:0]           occupancy
);

  localparam logic [TAG_W-1:0] TFREE = TAG_W'(TAG_FREE);

  // Returns {hit, data}; the lowest-numbered matching port wins.
  function automatic logic [DATA_W:0] cdb_fwd(
    input logic [TAG_W-1:0]       tag,
    input logic [DATA_W-1:0]      data,
    input logic [NCDB-1:0]        v,
    input logic [NCDB*TAG_W-1:0]  t,
    input logic [NCDB*DATA_W-1:0] d
  );
    logic [DATA_W:0] r;
    r = {1'b0, data};
    for (int k = NCDB - 1; k >= 0; k--) begin
      if (tag != TFREE && v[k] && t[k*TAG_W +: TAG_W] == tag) r = {1'b1, d[k*DATA_W +: DATA_W]};
    end
    return r;
  endfunction

  logic [DEPTH-1:0]  busy_q, busy_d, keep_s, rdy_s, hit1_s, hit2_s;
  logic [DATA_W-1:0] data1_q [DEPTH];
  logic [DATA_W-1:0] data2_q [DEPTH];
  logic [DATA_W-1:0] off_q   [DEPTH];
  logic [TAG_W-1:0]  tag1_q  [DEPTH];
  logic [TAG_W-1:0]  tag2_q  [DEPTH];
  logic [ADDR_W-1:0] pc_q    [DEPTH];
  logic [OP_W-1:0]   op_q    [DEPTH];
  logic [DEPTH-1:0]  older_q [DEPTH];
  logic [DATA_W-1:0] fw1_s   [DEPTH];
  logic [DATA_W-1:0] fw2_s   [DEPTH];
  logic [DATA_W-1:0] src1_s  [DEPTH];
  logic [DATA_W-1:0] src2_s  [DEPTH];

  logic              iv_q;
  logic [DATA_W-1:0] isrc1_q, isrc2_q, ioff_q;
  logic [ADDR_W-1:0] ipc_q;
  logic [OP_W-1:0]   iop_q;

  logic [SEL_W:0]    occ_s;
  logic [SEL_W-1:0]  free_idx_s, sel_idx_s;
  logic              sel_found_s, load_s, alloc_ready_s, alloc_fire_s, issue_fire_s;
  logic [DATA_W:0]   af1_s, af2_s;

  // Readiness, oldest-ready selection, free slot search and next busy vector.
  always_comb begin
    logic [DATA_W:0] f1, f2;
    occ_s       = '0;
    free_idx_s  = '0;
    sel_found_s = 1'b0;
    sel_idx_s   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      occ_s = occ_s + (SEL_W+1)'(busy_q[i]);
      if (!busy_q[i]) free_idx_s = SEL_W'(i);
      else            free_idx_s = free_idx_s;
      f1 = cdb_fwd(tag1_q[i], data1_q[i], cdb_valid, cdb_tag, cdb_data);
      f2 = cdb_fwd(tag2_q[i], data2_q[i], cdb_valid, cdb_tag, cdb_data);
      hit1_s[i] = f1[DATA_W];
      hit2_s[i] = f2[DATA_W];
      fw1_s[i]  = f1[DATA_W-1:0];
      fw2_s[i]  = f2[DATA_W-1:0];
`ifdef RS_BRANCH_WAKEUP_BYPASS_EN
      rdy_s[i]  = busy_q[i] && (tag1_q[i] == TFREE || hit1_s[i]) && (tag2_q[i] == TFREE || hit2_s[i]);
      src1_s[i] = fw1_s[i];
      src2_s[i] = fw2_s[i];
`else
      rdy_s[i]  = busy_q[i] && tag1_q[i] == TFREE && tag2_q[i] == TFREE;
      src1_s[i] = data1_q[i];
      src2_s[i] = data2_q[i];
`endif
    end
    // An entry is oldest-ready when no other ready entry is recorded as older than it.
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (rdy_s[i] && ((older_q[i] & rdy_s) == '0)) begin
        sel_found_s = 1'b1;
        sel_idx_s   = SEL_W'(i);
      end else begin
        sel_found_s = sel_found_s;
      end
    end
    load_s        = !iv_q || issue_ready;
    alloc_ready_s = occ_s < (SEL_W+1)'(DEPTH);
    alloc_fire_s  = alloc_valid && alloc_ready_s && !flush;
    issue_fire_s  = load_s && sel_found_s && !flush;
    keep_s        = busy_q;
    if (issue_fire_s) keep_s[sel_idx_s] = 1'b0;
    else              keep_s = busy_q;
    busy_d = keep_s;
    if (alloc_fire_s) busy_d[free_idx_s] = 1'b1;
    else              busy_d = keep_s;
    if (flush) busy_d = '0;
    else       busy_d = busy_d;
    af1_s = cdb_fwd(alloc_tag1, alloc_data1, cdb_valid, cdb_tag, cdb_data);
    af2_s = cdb_fwd(alloc_tag2, alloc_data2, cdb_valid, cdb_tag, cdb_data);
  end

  // Entry and issue-register state; flush suppresses wakeup, issue and allocation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= '0;
      iv_q    <= 1'b0;
      isrc1_q <= '0;
      isrc2_q <= '0;
      ioff_q  <= '0;
      ipc_q   <= '0;
      iop_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data1_q[i] <= '0;
        data2_q[i] <= '0;
        off_q[i]   <= '0;
        tag1_q[i]  <= TFREE;
        tag2_q[i]  <= TFREE;
        pc_q[i]    <= '0;
        op_q[i]    <= '0;
        older_q[i] <= '0;
      end
    end else begin
      busy_q <= busy_d;
      if (flush) begin
        iv_q <= 1'b0;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (busy_q[i] && hit1_s[i]) begin
            tag1_q[i]  <= TFREE;
            data1_q[i] <= fw1_s[i];
          end
          if (busy_q[i] && hit2_s[i]) begin
            tag2_q[i]  <= TFREE;
            data2_q[i] <= fw2_s[i];
          end
        end
        if (load_s) begin
          iv_q <= sel_found_s;
          if (sel_found_s) begin
            isrc1_q <= src1_s[sel_idx_s];
            isrc2_q <= src2_s[sel_idx_s];
            ioff_q  <= off_q[sel_idx_s];
            ipc_q   <= pc_q[sel_idx_s];
            iop_q   <= op_q[sel_idx_s];
          end
        end
        if (alloc_fire_s) begin
          data1_q[free_idx_s] <= af1_s[DATA_W-1:0];
          data2_q[free_idx_s] <= af2_s[DATA_W-1:0];
          tag1_q[free_idx_s]  <= af1_s[DATA_W] ? TFREE : alloc_tag1;
          tag2_q[free_idx_s]  <= af2_s[DATA_W] ? TFREE : alloc_tag2;
          off_q[free_idx_s]   <= alloc_offset;
          pc_q[free_idx_s]    <= alloc_pc;
          op_q[free_idx_s]    <= alloc_op;
          // New entry is younger than every survivor; nobody may count it as older.
          for (int i = 0; i < DEPTH; i++) begin
            if (SEL_W'(i) == free_idx_s) older_q[i] <= keep_s;
            else                         older_q[i][free_idx_s] <= 1'b0;
          end
        end
      end
    end
  end

  assign alloc_ready  = alloc_ready_s;
  assign occupancy    = occ_s;
  assign issue_valid  = iv_q;
  assign issue_src1   = isrc1_q;
  assign issue_src2   = isrc2_q;
  assign issue_offset = ioff_q;
  assign issue_pc     = ipc_q;
  assign issue_op     = iop_q;

endmodule
